fir_param: RTL and testbench

FIR_PARAM -- requirements
Module: fir_param

---
 rtl/fir_pkg.sv | 37 +++
 rtl/fir_param_if.sv | 31 +++
 rtl/fir_dly_ram.sv | 50 +++++
 rtl/fir_param.sv | 163 ++++++++++++++++
 tb/tb_fir_param.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the parameterised multi-channel FIR filter:
// controller state encoding and the output rounding/saturation helper.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_CALC  = 2'd2,
        ST_DONE  = 2'd3
    } fir_state_e;

    // Wide enough for any supported accumulator plus rounding headroom.
    localparam int RND_W = 64;

    // Converts a Q(COEF_W-1) scaled accumulator back to sample scale:
    // add half an LSB, arithmetic shift, then clamp to the signed
    // DATA_W range.
    function automatic logic signed [RND_W-1:0] rnd_sat(
        input logic signed [RND_W-1:0] acc,
        input int                      data_w,
        input int                      coef_w
    );
        logic signed [RND_W-1:0] r;
        logic signed [RND_W-1:0] hi;
        logic signed [RND_W-1:0] lo;
        r  = (acc + (64'sd1 <<< (coef_w - 2))) >>> (coef_w - 1);
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (r > hi) begin
            return hi;
        end else if (r < lo) begin
            return lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_param_if.sv
// Sample, coefficient-ROM and status signals of the FIR filter.
// master = system side (sample source, coefficient ROM), slave = filter.
interface fir_param_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 1023,
    parameter int NCH    = 2
);
    localparam int AW = $clog2(NTAPS);

    logic                    in_vld;
    logic [NCH*DATA_W-1:0]   smpl_in;
    logic [AW-1:0]           coef_addr;
    logic [COEF_W-1:0]       coef_dout;
    logic [NCH*DATA_W-1:0]   smpl_out;
    logic                    out_vld;
    logic                    busy;
    logic                    overrun;
    logic                    ovr_clr;

    modport master (
        output in_vld, smpl_in, coef_dout, ovr_clr,
        input  coef_addr, smpl_out, out_vld, busy, overrun
    );

    modport slave (
        input  in_vld, smpl_in, coef_dout, ovr_clr,
        output coef_addr, smpl_out, out_vld, busy, overrun
    );

endinterface

// File: rtl/fir_dly_ram.sv
// Circular delay-line storage: one write port, one registered read port.
// A per-entry written flag makes never-written locations read as zero,
// so a reset clears the whole line without touching the data array.
module fir_dly_ram #(
    parameter int DEPTH = 1023,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] written_q, written_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    // Next written flags and masked read data
    always_comb begin
        written_d = written_q;
        if (we) begin
            written_d[waddr] = 1'b1;
        end
        rdata_d = written_q[raddr] ? mem_q[raddr] : '0;
    end

    // Data array, no reset needed thanks to the written flags
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Written flags and read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            written_q <= '0;
            rdata_q   <= '0;
        end else begin
            written_q <= written_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fir_param.sv
// Time-multiplexed multi-channel FIR: one MAC per channel per cycle, all
// channels sharing one coefficient stream from an external ROM.
module fir_param
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 1023,
    parameter int NCH    = 2,
    parameter int ACC_W  = 40
) (
    input  logic      clk,
    input  logic      rst_n,
    fir_param_if.slave bus
);
    localparam int AW     = $clog2(NTAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SW     = NCH * DATA_W;
    localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);

    fir_state_e              state_q, state_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]           coef_addr_q, coef_addr_d;
    logic [AW-1:0]           k_q, k_d;
    logic signed [ACC_W-1:0] acc_q [NCH];
    logic signed [ACC_W-1:0] acc_d [NCH];
    logic [SW-1:0]           smpl_out_q, smpl_out_d;
    logic                    out_vld_q, out_vld_d;
    logic                    overrun_q, overrun_d;

    logic                     accept;
    logic [SW-1:0]            dly_rd;
    logic signed [COEF_W-1:0] coef_s;
    logic signed [DATA_W-1:0] x_s  [NCH];
    logic signed [PROD_W-1:0] prod [NCH];
    logic signed [RND_W-1:0]  rnd  [NCH];

    assign accept = bus.in_vld && (state_q == ST_IDLE);
    assign coef_s = bus.coef_dout;

    fir_dly_ram #(
        .DEPTH (NTAPS),
        .WIDTH (SW),
        .AW    (AW)
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .waddr (wr_ptr_q),
        .wdata (bus.smpl_in),
        .raddr (rd_ptr_q),
        .rdata (dly_rd)
    );

    // Per-channel full-precision products and rounded/saturated results
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            x_s[c]  = dly_rd[c*DATA_W +: DATA_W];
            prod[c] = PROD_W'(x_s[c]) * PROD_W'(coef_s);
            rnd[c]  = rnd_sat($signed({{(RND_W-ACC_W){acc_q[c][ACC_W-1]}}, acc_q[c]}),
                              DATA_W, COEF_W);
        end
    end

    // Controller and MAC next-state
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        coef_addr_d = coef_addr_q;
        k_d         = k_q;
        acc_d       = acc_q;
        smpl_out_d  = smpl_out_q;
        out_vld_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wr_ptr_d    = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
                    rd_ptr_d    = wr_ptr_q;
                    coef_addr_d = '0;
                    state_d     = ST_PRIME;
                end
            end
            ST_PRIME: begin
                // Tap 0 address and newest sample are being read this cycle
                for (int c = 0; c < NCH; c++) begin
                    acc_d[c] = '0;
                end
                coef_addr_d = coef_addr_q + 1'b1;
                rd_ptr_d    = (rd_ptr_q == '0) ? LAST_IDX : rd_ptr_q - 1'b1;
                k_d         = '0;
                state_d     = ST_CALC;
            end
            ST_CALC: begin
                for (int c = 0; c < NCH; c++) begin
                    acc_d[c] = acc_q[c] + $signed({{(ACC_W-PROD_W){prod[c][PROD_W-1]}}, prod[c]});
                end
                coef_addr_d = (coef_addr_q == LAST_IDX) ? '0 : coef_addr_q + 1'b1;
                rd_ptr_d    = (rd_ptr_q == '0) ? LAST_IDX : rd_ptr_q - 1'b1;
                k_d         = k_q + 1'b1;
                if (k_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                for (int c = 0; c < NCH; c++) begin
                    smpl_out_d[c*DATA_W +: DATA_W] = rnd[c][DATA_W-1:0];
                end
                out_vld_d   = 1'b1;
                coef_addr_d = '0;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky overrun: a new event wins over a simultaneous clear
    always_comb begin
        overrun_d = overrun_q;
        if (bus.ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (bus.in_vld && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            coef_addr_q <= '0;
            k_q         <= '0;
            for (int c = 0; c < NCH; c++) begin
                acc_q[c] <= '0;
            end
            smpl_out_q  <= '0;
            out_vld_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            coef_addr_q <= coef_addr_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            smpl_out_q  <= smpl_out_d;
            out_vld_q   <= out_vld_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.coef_addr = coef_addr_q;
    assign bus.smpl_out  = smpl_out_q;
    assign bus.out_vld   = out_vld_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_fir_param.sv
// Directed bench for fir_param with NTAPS=4, NCH=2, 16-bit data/coefs.
module tb_fir_param;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [15:0] rom [4];

    fir_param_if #(.DATA_W(16), .COEF_W(16), .NTAPS(4), .NCH(2)) bus ();

    fir_param #(
        .DATA_W (16),
        .COEF_W (16),
        .NTAPS  (4),
        .NCH    (2),
        .ACC_W  (40)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous coefficient ROM: data one clock after address
    always @(posedge clk) bus.coef_dout <= rom[bus.coef_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rom(input logic [15:0] c0, input logic [15:0] c1,
                           input logic [15:0] c2, input logic [15:0] c3);
        rom[0] = c0; rom[1] = c1; rom[2] = c2; rom[3] = c3;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.in_vld  = 1'b0;
        bus.ovr_clr = 1'b0;
        bus.smpl_in = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Drives one sample and waits (bounded) for the result strobe.
    task automatic send(input logic [31:0] s, output int cyc, output logic [31:0] o);
        bus.smpl_in = s;
        bus.in_vld  = 1'b1;
        tick();
        bus.in_vld  = 1'b0;
        cyc = -1;
        o   = 'x;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.out_vld === 1'b1 && cyc < 0) begin
                cyc = i;
                o   = bus.smpl_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        set_rom(16'h0, 16'h0, 16'h0, 16'h0);
        do_reset();
        checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b want 0", bus.out_vld); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
        checks++; if (bus.smpl_out !== 32'h0) begin errors++; $display("FAIL reset_smpl_out: got %h want 0", bus.smpl_out); end
        checks++; if (bus.coef_addr !== 2'd0) begin errors++; $display("FAIL reset_coef_addr: got %0d want 0", bus.coef_addr); end
    endtask

    task automatic test_impulse();
        int          cyc;
        logic [31:0] o;
        logic        exp_v;
        logic        exp_b;
        set_rom(16'h4000, 16'h0, 16'h0, 16'h0);
        do_reset();
        bus.smpl_in = 32'h2000_2000;
        bus.in_vld  = 1'b1;
        tick();
        bus.in_vld  = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL impulse_busy_prime: got %b want 1", bus.busy); end
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp_v = (i == 6);
            exp_b = (i <= 5);
            checks++; if (bus.out_vld !== exp_v) begin errors++; $display("FAIL impulse_out_vld c%0d: got %b want %b", i, bus.out_vld, exp_v); end
            checks++; if (bus.busy !== exp_b) begin errors++; $display("FAIL impulse_busy c%0d: got %b want %b", i, bus.busy, exp_b); end
        end
        checks++; if (bus.smpl_out !== 32'h1000_1000) begin errors++; $display("FAIL impulse_out: got %h want 10001000", bus.smpl_out); end
        tick();
        checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL impulse_vld_drop: got %b want 0", bus.out_vld); end
        checks++; if (bus.smpl_out !== 32'h1000_1000) begin errors++; $display("FAIL impulse_hold: got %h want 10001000", bus.smpl_out); end
        send(32'hE000_2000, cyc, o);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL impulse2_latency: got %0d want 6", cyc); end
        checks++; if (o !== 32'hF000_1000) begin errors++; $display("FAIL impulse2_out: got %h want f0001000", o); end
    endtask

    task automatic test_saturate();
        int          cyc;
        logic [31:0] o;
        logic [31:0] exp_o;
        set_rom(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        do_reset();
        for (int n = 1; n <= 4; n++) begin
            send(32'h8000_7FFF, cyc, o);
            exp_o = (n == 1) ? 32'h8001_7FFE : 32'h8000_7FFF;
            checks++; if (o !== exp_o) begin errors++; $display("FAIL saturate_out n%0d: got %h want %h", n, o, exp_o); end
        end
        checks++; if (cyc !== 6) begin errors++; $display("FAIL saturate_latency: got %0d want 6", cyc); end
    endtask

    task automatic test_unit_delay();
        int          cyc;
        logic [31:0] o;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp_o;
        set_rom(16'h0, 16'h7FFF, 16'h0, 16'h0);
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            a = 16'(n);
            b = 16'(-n);
            exp_o = {16'(-(n - 1)), 16'(n - 1)};
            send({b, a}, cyc, o);
            checks++; if (o !== exp_o) begin errors++; $display("FAIL unit_delay_out n%0d: got %h want %h", n, o, exp_o); end
        end
        checks++; if (cyc !== 6) begin errors++; $display("FAIL unit_delay_latency: got %0d want 6", cyc); end
    endtask

    task automatic test_overrun();
        set_rom(16'h4000, 16'h4000, 16'h0, 16'h0);
        do_reset();
        bus.smpl_in = 32'h2000_2000;
        bus.in_vld  = 1'b1;
        tick();
        bus.in_vld  = 1'b0;
        tick();
        tick();
        bus.smpl_in = 32'h7000_7000;
        bus.in_vld  = 1'b1;
        tick();
        bus.in_vld  = 1'b0;
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", bus.overrun); end
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr: got %b want 0", bus.overrun); end
        tick();
        bus.smpl_in = 32'h7000_7000;
        bus.in_vld  = 1'b1;
        tick();
        bus.in_vld  = 1'b0;
        checks++; if (bus.out_vld !== 1'b1) begin errors++; $display("FAIL overrun_run_vld: got %b want 1", bus.out_vld); end
        checks++; if (bus.smpl_out !== 32'h1000_1000) begin errors++; $display("FAIL overrun_run_out: got %h want 10001000", bus.smpl_out); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_done_cycle: got %b want 1", bus.overrun); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL overrun_done_dropped: got busy %b want 0", bus.busy); end
        bus.smpl_in = 32'h0800_0800;
        bus.in_vld  = 1'b1;
        tick();
        bus.in_vld  = 1'b0;
        tick();
        tick();
        bus.in_vld  = 1'b1;
        bus.ovr_clr = 1'b1;
        tick();
        bus.in_vld  = 1'b0;
        bus.ovr_clr = 1'b0;
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL overrun_clr_vs_set: got %b want 1", bus.overrun); end
        tick();
        tick();
        tick();
        checks++; if (bus.out_vld !== 1'b1) begin errors++; $display("FAIL overrun_next_vld: got %b want 1", bus.out_vld); end
        checks++; if (bus.smpl_out !== 32'h1400_1400) begin errors++; $display("FAIL overrun_next_out: got %h want 14001400", bus.smpl_out); end
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL overrun_final_clr: got %b want 0", bus.overrun); end
    endtask

    task automatic test_reset_mid();
        int          cyc;
        int          vld_seen;
        logic [31:0] o;
        set_rom(16'h4000, 16'h0, 16'h0, 16'h0);
        do_reset();
        send(32'h2000_2000, cyc, o);
        checks++; if (o !== 32'h1000_1000) begin errors++; $display("FAIL reset_mid_pre: got %h want 10001000", o); end
        bus.smpl_in = 32'h2000_2000;
        bus.in_vld  = 1'b1;
        tick();
        bus.in_vld  = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_vld !== 1'b0) begin errors++; $display("FAIL reset_mid_vld: got %b want 0", bus.out_vld); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b want 0", bus.busy); end
        checks++; if (bus.smpl_out !== 32'h0) begin errors++; $display("FAIL reset_mid_out: got %h want 0", bus.smpl_out); end
        checks++; if (bus.coef_addr !== 2'd0) begin errors++; $display("FAIL reset_mid_addr: got %0d want 0", bus.coef_addr); end
        tick();
        rst_n = 1'b1;
        vld_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_vld === 1'b1) vld_seen++;
        end
        checks++; if (vld_seen !== 0) begin errors++; $display("FAIL reset_mid_no_vld: got %0d strobes want 0", vld_seen); end
        send(32'h2000_2000, cyc, o);
        checks++; if (cyc !== 6) begin errors++; $display("FAIL reset_mid_latency: got %0d want 6", cyc); end
        checks++; if (o !== 32'h1000_1000) begin errors++; $display("FAIL reset_mid_fresh: got %h want 10001000", o); end
    endtask

    task automatic test_rounding();
        int          cyc;
        logic [31:0] o;
        set_rom(16'h0001, 16'h0, 16'h0, 16'h0);
        do_reset();
        send(32'h3FFF_4000, cyc, o);
        checks++; if (o !== 32'h0000_0001) begin errors++; $display("FAIL rounding_pos: got %h want 00000001", o); end
        send(32'hBFFF_C000, cyc, o);
        checks++; if (o !== 32'hFFFF_0000) begin errors++; $display("FAIL rounding_neg: got %h want ffff0000", o); end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        bus.in_vld  = 1'b0;
        bus.ovr_clr = 1'b0;
        bus.smpl_in = '0;
        test_reset();
        test_impulse();
        test_saturate();
        test_unit_delay();
        test_overrun();
        test_reset_mid();
        test_rounding();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
